dense_layer_sequencer: RTL and testbench

Hardware sequencer for one quantized fully-connected layer (MNIST MLP class: 784→N→N→10). It walks the input, weight and bias memories and drives the shared mult16bvia8bit multiplier with zero-point-shifted operands. It accumulates into 32 bits, adds bias, applies optional ReLU, requantizes with a fixed-point multiplier/shift, and writes 8-bit outputs. The layer runner steps it once per layer.

---
 rtl/dense_pkg.sv | 28 ++
 rtl/dense_requant.sv | 30 +++
 rtl/dense_layer_sequencer.sv | 147 ++++++++++++++
 tb/tb_dense_layer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and fixed-point helpers for the quantized dense-layer sequencer.
// The layer runner and the requantizer both import this package.
package dense_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    REQ,
    WR,
    DONE
  } state_t;

  localparam int ACC_W  = 32;
  localparam int PROD_W = 64;
  localparam int Q31    = 31;

  // Right-shift applied after the Q31 multiply; legal quant_shift keeps this in 1..62.
  function automatic logic [5:0] total_shift(input logic [31:0] quant_shift);
    return 6'(32'(Q31) - quant_shift);
  endfunction

  // Half an output LSB, added before the shift so the result rounds to nearest.
  function automatic logic signed [PROD_W-1:0] round_bias(input logic [5:0] shift);
    return PROD_W'(1) << (shift - 6'd1);
  endfunction

endpackage

// File: rtl/dense_requant.sv
// Combinational requantizer: optional ReLU, Q31 multiply, rounding shift and
// output zero-point add. Produces the low byte only; there is no saturation.
module dense_requant
  import dense_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic             relu_en,
  input  logic [31:0]      quant_mult,
  input  logic [31:0]      quant_shift,
  input  logic [7:0]       output_zp,
  output logic [7:0]       q
);

  logic [5:0]               shift;
  logic signed [PROD_W-1:0] r64;
  logic signed [PROD_W-1:0] m64;
  logic signed [PROD_W-1:0] zp64;
  logic signed [PROD_W-1:0] p64;

  always_comb begin
    shift = total_shift(quant_shift);
    r64   = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
    if (relu_en && acc[ACC_W-1]) r64 = '0;
    m64   = {{32{quant_mult[31]}}, quant_mult};
    zp64  = {{56{output_zp[7]}}, output_zp};
    p64   = r64 * m64 + round_bias(shift);
    q     = 8'((p64 >>> shift) + zp64);
  end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Steps one quantized fully-connected layer: walks input/weight/bias memories,
// accumulates zero-point-shifted products, requantizes and writes one byte per neuron.
module dense_layer_sequencer
  import dense_pkg::*;
#(
  parameter int IN_MAX  = 1024,
  parameter int OUT_MAX = 256,
  parameter int IA_W    = $clog2(IN_MAX),
  parameter int OA_W    = $clog2(OUT_MAX),
  parameter int WA_W    = $clog2(IN_MAX * OUT_MAX)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [IA_W:0]   i_in_len,
  input  logic [OA_W:0]   i_out_len,
  input  logic [7:0]      i_input_zp,
  input  logic [7:0]      i_filter_zp,
  input  logic [7:0]      i_output_zp,
  input  logic [31:0]     i_quant_mult,
  input  logic [31:0]     i_quant_shift,
  input  logic            i_relu_en,
  output logic [IA_W-1:0] o_in_addr,
  input  logic [7:0]      i_in_data,
  output logic [WA_W-1:0] o_w_addr,
  input  logic [7:0]      i_w_data,
  output logic [OA_W-1:0] o_b_addr,
  input  logic [31:0]     i_b_data,
  output logic [15:0]     o_mul_a,
  output logic [15:0]     o_mul_b,
  input  logic [31:0]     i_mul_p,
  output logic            o_out_we,
  output logic [OA_W-1:0] o_out_addr,
  output logic [7:0]      o_out_data,
  output logic            o_busy,
  output logic            o_done
);

  state_t state, state_nxt;

  logic [IA_W:0]      in_len_q;
  logic [OA_W:0]      out_len_q;
  logic [7:0]         input_zp_q, filter_zp_q, output_zp_q;
  logic [31:0]        quant_mult_q, quant_shift_q;
  logic               relu_en_q;
  logic [OA_W-1:0]    j;
  logic [ACC_W-1:0]   acc;
  logic [7:0]         q_reg, q_next;
  logic               last_i, last_j, rd_valid;

  assign last_i = ({1'b0, o_in_addr} == in_len_q - (IA_W+1)'(1));
  assign last_j = ({1'b0, j} == out_len_q - (OA_W+1)'(1));

  // Memory reads lag the address by one cycle, so the product stream runs from
  // the second MAC cycle through DRAIN; operands are zero everywhere else.
  assign rd_valid = (state == MAC && o_in_addr != '0) || state == DRAIN;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start) state_nxt = (i_out_len == '0) ? DONE : MAC;
      MAC:     if (last_i) state_nxt = DRAIN;
      DRAIN:   state_nxt = REQ;
      REQ:     state_nxt = WR;
      WR:      state_nxt = last_j ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_len_q      <= '0;
      out_len_q     <= '0;
      input_zp_q    <= '0;
      filter_zp_q   <= '0;
      output_zp_q   <= '0;
      quant_mult_q  <= '0;
      quant_shift_q <= '0;
      relu_en_q     <= 1'b0;
      o_in_addr     <= '0;
      o_w_addr      <= '0;
      j             <= '0;
      acc           <= '0;
      q_reg         <= '0;
    end else begin
      unique case (state)
        IDLE: if (i_start) begin
          in_len_q      <= i_in_len;
          out_len_q     <= i_out_len;
          input_zp_q    <= i_input_zp;
          filter_zp_q   <= i_filter_zp;
          output_zp_q   <= i_output_zp;
          quant_mult_q  <= i_quant_mult;
          quant_shift_q <= i_quant_shift;
          relu_en_q     <= i_relu_en;
          o_in_addr     <= '0;
          o_w_addr      <= '0;
          j             <= '0;
        end
        MAC: begin
          acc <= (o_in_addr == '0) ? '0 : acc + i_mul_p;
          if (!last_i) begin
            o_in_addr <= o_in_addr + IA_W'(1);
            o_w_addr  <= o_w_addr + WA_W'(1);
          end
        end
        DRAIN: acc <= acc + i_mul_p + i_b_data;
        REQ:   q_reg <= q_next;
        // Rows are contiguous, so the next neuron's first weight follows the last one.
        WR: if (!last_j) begin
          j         <= j + OA_W'(1);
          o_in_addr <= '0;
          o_w_addr  <= o_w_addr + WA_W'(1);
        end
        default: ;
      endcase
    end
  end

  dense_requant u_requant (
    .acc         (acc),
    .relu_en     (relu_en_q),
    .quant_mult  (quant_mult_q),
    .quant_shift (quant_shift_q),
    .output_zp   (output_zp_q),
    .q           (q_next)
  );

  assign o_mul_a    = rd_valid ? ({{8{i_in_data[7]}}, i_in_data} - {{8{input_zp_q[7]}}, input_zp_q}) : '0;
  assign o_mul_b    = rd_valid ? ({{8{i_w_data[7]}}, i_w_data} - {{8{filter_zp_q[7]}}, filter_zp_q}) : '0;
  assign o_b_addr   = j;
  assign o_out_we   = (state == WR);
  assign o_out_addr = (state == WR) ? j : '0;
  assign o_out_data = (state == WR) ? q_reg : '0;
  assign o_busy     = (state == MAC) || (state == DRAIN) || (state == REQ) || (state == WR);
  assign o_done     = (state == DONE);

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Self-checking bench for dense_layer_sequencer: directed and random layers
// compared against an arithmetic reference model of the quantized layer.
module tb_dense_layer_sequencer;

  localparam int IN_MAX  = 1024;
  localparam int OUT_MAX = 256;
  localparam int IA_W    = 10;
  localparam int OA_W    = 8;
  localparam int WA_W    = 18;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IA_W:0]   in_len;
  logic [OA_W:0]   out_len;
  logic [7:0]      input_zp, filter_zp, output_zp;
  logic [31:0]     quant_mult, quant_shift;
  logic            relu_en;
  logic [IA_W-1:0] in_addr;
  logic [7:0]      in_data;
  logic [WA_W-1:0] w_addr;
  logic [7:0]      w_data;
  logic [OA_W-1:0] b_addr;
  logic [31:0]     b_data;
  logic [15:0]     mul_a, mul_b;
  logic [31:0]     mul_p;
  logic            out_we;
  logic [OA_W-1:0] out_addr;
  logic [7:0]      out_data;
  logic            busy, done;

  always #5 clk = ~clk;

  dense_layer_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_in_len      (in_len),
    .i_out_len     (out_len),
    .i_input_zp    (input_zp),
    .i_filter_zp   (filter_zp),
    .i_output_zp   (output_zp),
    .i_quant_mult  (quant_mult),
    .i_quant_shift (quant_shift),
    .i_relu_en     (relu_en),
    .o_in_addr     (in_addr),
    .i_in_data     (in_data),
    .o_w_addr      (w_addr),
    .i_w_data      (w_data),
    .o_b_addr      (b_addr),
    .i_b_data      (b_data),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .i_mul_p       (mul_p),
    .o_out_we      (out_we),
    .o_out_addr    (out_addr),
    .o_out_data    (out_data),
    .o_busy        (busy),
    .o_done        (done)
  );

  // Memories with one-cycle synchronous read, and a combinational multiplier.
  logic [7:0]  in_mem [IN_MAX];
  logic [7:0]  w_mem  [IN_MAX*OUT_MAX];
  logic [31:0] b_mem  [OUT_MAX];

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  always_comb mul_p = $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t wr_q[$];
  int  ops_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_we) wr_q.push_back('{addr: int'(out_addr), data: int'(out_data)});
      if ((!busy || out_we) && (mul_a != '0 || mul_b != '0)) ops_bad <= ops_bad + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  int cfg_in_len, cfg_out_len, cfg_izp, cfg_fzp, cfg_ozp, cfg_mult, cfg_shift;
  bit cfg_relu;

  task automatic apply_cfg();
    in_len      = (IA_W+1)'(cfg_in_len);
    out_len     = (OA_W+1)'(cfg_out_len);
    input_zp    = 8'(cfg_izp);
    filter_zp   = 8'(cfg_fzp);
    output_zp   = 8'(cfg_ozp);
    quant_mult  = 32'(cfg_mult);
    quant_shift = 32'(cfg_shift);
    relu_en     = cfg_relu;
  endtask

  // Reference: integer dot product with zero points, 32-bit wrap, bias, ReLU,
  // then Q31 rounding requantization with 64-bit intermediates.
  function automatic logic [7:0] model_out(input int j);
    int     acc, r, ts;
    byte    x, w;
    longint p;
    acc = 0;
    for (int i = 0; i < cfg_in_len; i++) begin
      x = byte'(in_mem[i]);
      w = byte'(w_mem[j*cfg_in_len + i]);
      acc += (int'(x) - cfg_izp) * (int'(w) - cfg_fzp);
    end
    acc += int'(b_mem[j]);
    r  = (cfg_relu && acc < 0) ? 0 : acc;
    ts = 31 - cfg_shift;
    p  = longint'(r) * longint'(cfg_mult) + (longint'(1) << (ts - 1));
    return 8'((p >>> ts) + longint'(cfg_ozp));
  endfunction

  task automatic randomize_mem(input int n_in, input int n_out);
    for (int i = 0; i < n_in; i++) in_mem[i] = 8'($urandom);
    for (int k = 0; k < n_in*n_out; k++) w_mem[k] = 8'($urandom);
    for (int j = 0; j < n_out; j++) b_mem[j] = 32'($urandom_range(0, 40000)) - 32'd20000;
  endtask

  task automatic randomize_cfg(input int n_in, input int n_out);
    cfg_in_len  = n_in;
    cfg_out_len = n_out;
    cfg_izp     = int'($urandom_range(0, 255)) - 128;
    cfg_fzp     = int'($urandom_range(0, 255)) - 128;
    cfg_ozp     = int'($urandom_range(0, 255)) - 128;
    cfg_mult    = int'($urandom);
    cfg_shift   = 30 - int'($urandom_range(0, 61));
    cfg_relu    = 1'($urandom);
  endtask

  // Runs one layer from the current cfg_* and memories; glitch_at>0 pulses a
  // conflicting start that many cycles into the layer.
  task automatic run_layer(input string name, input int glitch_at);
    int c0, lat, budget, bad0;
    bit got, busy_at_done;
    wr_q.delete();
    bad0 = ops_bad;
    apply_cfg();
    start = 1'b1;
    c0 = cyc;
    got = 1'b0;
    lat = 0;
    busy_at_done = 1'b0;
    budget = cfg_out_len * (cfg_in_len + 3) + 20;
    for (int n = 0; n < budget && !got; n++) begin
      if (n == glitch_at) begin
        start   = 1'b1;
        in_len  = (IA_W+1)'(3);
        out_len = (OA_W+1)'(2);
      end
      @(negedge clk);
      start = 1'b0;
      apply_cfg();
      if (done) begin
        got = 1'b1;
        lat = cyc - c0;
        busy_at_done = busy;
      end
    end
    repeat (3) @(negedge clk);
    check({name, "_done_seen"}, got, 1);
    check({name, "_latency"}, lat, cfg_out_len * (cfg_in_len + 3) + 1);
    check({name, "_busy_at_done"}, busy_at_done, 0);
    check({name, "_writes"}, wr_q.size(), cfg_out_len);
    check({name, "_ops_idle_zero"}, ops_bad - bad0, 0);
    for (int k = 0; k < wr_q.size() && k < cfg_out_len; k++) begin
      check($sformatf("%s_addr%0d", name, k), wr_q[k].addr, k);
      check($sformatf("%s_data%0d", name, k), wr_q[k].data, int'(model_out(k)));
    end
  endtask

  task automatic set_small(input int x0, input int x1, input int w0, input int w1, input int b0);
    in_mem[0] = 8'(x0);
    in_mem[1] = 8'(x1);
    w_mem[0]  = 8'(w0);
    w_mem[1]  = 8'(w1);
    b_mem[0]  = 32'(b0);
    cfg_in_len = 2; cfg_out_len = 1;
    cfg_izp = 0; cfg_fzp = 0; cfg_ozp = 0;
    cfg_mult = 1 << 30; cfg_shift = 0; cfg_relu = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < IN_MAX; i++) in_mem[i] = '0;
    for (int k = 0; k < IN_MAX*OUT_MAX; k++) w_mem[k] = '0;
    for (int j = 0; j < OUT_MAX; j++) b_mem[j] = '0;
    set_small(0, 0, 0, 0, 0);
    apply_cfg();
    repeat (3) @(negedge clk);

    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_we", out_we, 0);
    check("reset_mul", {mul_a, mul_b}, 0);
    check("reset_addr", {in_addr, w_addr, b_addr, out_addr, out_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product: 3*2 + 5*4 + 10 = 36 -> 18.
    set_small(3, 5, 2, 4, 10);
    run_layer("basic", -1);
    if (wr_q.size() > 0) check("basic_literal", wr_q[0].data, 18);

    set_small(3, 5, 2, 4, 10);
    cfg_ozp = -128;
    run_layer("ozp", -1);
    if (wr_q.size() > 0) check("ozp_literal", wr_q[0].data, 8'h92);

    set_small(3, 5, 2, 4, 10);
    cfg_izp = 1; cfg_fzp = 1;
    run_layer("zp_in", -1);
    if (wr_q.size() > 0) check("zp_in_literal", wr_q[0].data, 12);

    set_small(3, 5, -4, -4, 0);
    cfg_relu = 1'b1; cfg_ozp = 7;
    run_layer("relu_on", -1);
    if (wr_q.size() > 0) check("relu_on_literal", wr_q[0].data, 7);

    set_small(3, 5, -4, -4, 0);
    run_layer("relu_off", -1);
    if (wr_q.size() > 0) check("relu_off_literal", wr_q[0].data, 8'hF0);

    // Empty layer: done one cycle after start, no writes.
    cfg_out_len = 0;
    run_layer("empty", -1);

    // Single-input neurons.
    randomize_cfg(1, 4);
    randomize_mem(1, 4);
    run_layer("len1", -1);

    for (int t = 0; t < 4; t++) begin
      randomize_cfg(int'($urandom_range(1, 12)), int'($urandom_range(1, 6)));
      randomize_mem(cfg_in_len, cfg_out_len);
      run_layer($sformatf("rnd%0d", t), -1);
    end

    // Full MNIST-sized hidden layer with a stray start pulse mid-layer.
    randomize_cfg(784, 32);
    randomize_mem(784, 32);
    run_layer("mnist", 5000);

    // Reset dropped during the MAC phase of neuron 3.
    randomize_cfg(20, 6);
    randomize_mem(20, 6);
    wr_q.delete();
    apply_cfg();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 400 && seen < 3; n++) begin
      @(negedge clk);
      if (out_we) seen++;
    end
    check("abort_pre_writes", seen, 3);
    repeat (4) @(negedge clk);
    check("abort_in_mac_addr", in_addr, 3);
    check("abort_in_mac_neuron", b_addr, 3);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_outputs", {out_we, done, out_addr, out_data}, 0);
    check("abort_mul", {mul_a, mul_b}, 0);
    check("abort_addr", {in_addr, w_addr, b_addr}, 0);
    seen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done || out_we) seen++;
    end
    check("abort_no_activity", seen, 0);
    check("abort_write_total", wr_q.size(), 3);
    run_layer("after_abort", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
